// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and default widths for the instruction-fetch front end.
//   fetch_state_e : RUN (normal fetching) / DRAIN (discarding stale responses)
//   fetch_entry_t : {pc, instr} pair at the default widths
//   FETCH_AW      : default PC / memory address width
//   FETCH_DW      : default instruction width
package fetch_pkg;

  localparam int FETCH_AW = 8;
  localparam int FETCH_DW = 16;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Small synchronous FIFO with flush. Used both as the tag FIFO (PCs of
//   outstanding reads) and as the {pc,instr} output buffer.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail
//   pop        : drop the head entry
//   flush      : empty the FIFO (wins over push/pop)
//   head_data  : entry at the head (valid when !empty)
//   count      : number of stored entries
//   full/empty : occupancy flags
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until count says it was written.
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction-fetch front end between the program counter and decode.
//   Issues in-order reads at pc_in, tags each response with its PC and
//   buffers {pc,instr} for decode. Branch redirects reload the PC, flush the
//   output buffer and discard reads still in flight (DRAIN state).
//   clk, rst          : clock, synchronous active-high reset
//   pc_in             : current PC from the counter
//   pc_en/pc_load/pc_data : counter increment / load strobe / load value
//   mem_req/mem_addr/mem_gnt : read request handshake
//   mem_rvalid/mem_rdata     : in-order read responses
//   redirect_valid/redirect_pc : branch taken / flush and new target
//   out_valid/out_ready/out_pc/out_instr : decode handshake
//   Optional (FETCH_QUEUE_PERF_EN): perf_stall_cnt, perf_flush_cnt
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int AW      = FETCH_AW,
  parameter int DW      = FETCH_DW,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_in,
  output logic          pc_en,
  output logic          pc_load,
  output logic [AW-1:0] pc_data,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_pc,
  output logic [DW-1:0] out_instr
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [15:0]   perf_stall_cnt,
  output logic [7:0]    perf_flush_cnt
`endif
);

  localparam int TCW = $clog2(MAX_OUT) + 1;
  localparam int OCW = $clog2(DEPTH) + 1;
  localparam logic [OCW:0] DEPTH_L = (OCW + 1)'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } entry_t;

  fetch_state_e   state_q, state_d;

  logic           tag_push, tag_pop, tag_full, tag_empty;
  logic [TCW-1:0] tag_count, tag_count_nxt;
  logic [AW-1:0]  tag_head;

  logic           out_push, out_pop, out_flush, out_full, out_empty;
  logic [OCW-1:0] out_count;
  entry_t         out_head, out_entry;

  // Credits in use: reads in flight plus entries already buffered.
  logic [OCW:0]   inflight;

  assign inflight = (OCW + 1)'(tag_count) + (OCW + 1)'(out_count);
  assign mem_addr = pc_in;
  assign pc_en    = mem_req & mem_gnt;

  assign out_entry.pc    = tag_head;
  assign out_entry.instr = mem_rdata;

  // Outputs come straight from the buffer head, forced to zero when empty.
  assign out_valid = ~out_empty;
  assign out_pc    = out_empty ? '0 : out_head.pc;
  assign out_instr = out_empty ? '0 : out_head.instr;

  // Issue / response / redirect control and next state. Redirect dominates:
  // no issue that cycle, the output buffer is flushed and any response that
  // lands the same cycle is treated as stale (its tag is still retired).
  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    pc_load       = 1'b0;
    pc_data       = '0;
    tag_push      = 1'b0;
    tag_pop       = 1'b0;
    out_push      = 1'b0;
    out_pop       = 1'b0;
    out_flush     = 1'b0;
    tag_count_nxt = tag_count;
    if (!rst) begin
      tag_pop = mem_rvalid & ~tag_empty;
      if (redirect_valid) begin
        pc_load   = 1'b1;
        pc_data   = redirect_pc;
        out_flush = 1'b1;
      end else if (state_q == RUN) begin
        mem_req  = ~tag_full & (inflight < DEPTH_L);
        tag_push = mem_req & mem_gnt;
        out_push = tag_pop & ~out_full;
        out_pop  = ~out_empty & out_ready;
      end
      tag_count_nxt = tag_count + TCW'(tag_push) - TCW'(tag_pop);
      if (redirect_valid) begin
        state_d = (tag_count_nxt != '0) ? DRAIN : RUN;
      end else if (state_q == DRAIN && tag_count_nxt == '0) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Tag FIFO is never flushed: stale tags retire one per response in DRAIN.
  fetch_fifo #(.WIDTH(AW), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (pc_in),
    .pop       (tag_pop),
    .flush     (1'b0),
    .head_data (tag_head),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  fetch_fifo #(.WIDTH(AW + DW), .DEPTH(DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (out_push),
    .push_data (out_entry),
    .pop       (out_pop),
    .flush     (out_flush),
    .head_data (out_head),
    .count     (out_count),
    .full      (out_full),
    .empty     (out_empty)
  );

`ifdef FETCH_QUEUE_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;

  // Saturating event counters: starved decode cycles while fetching, redirects.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_empty && state_q == RUN && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (redirect_valid && flush_cnt_q != 8'hFF)
      flush_cnt_d = flush_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Bench for fetch_queue. Models the program counter and an in-order memory
//   with configurable latency; a scoreboard queue holds the {pc,instr} pair
//   expected for every granted read and is compared as decode accepts data.
module tb_fetch_queue;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc_in;
  logic          pc_en, pc_load;
  logic [AW-1:0] pc_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid, out_ready;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_instr;
`ifdef FETCH_QUEUE_PERF_EN
  logic [15:0]   perf_stall_cnt;
  logic [7:0]    perf_flush_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int mem_lat;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    pend_addr[$];
  int               pend_due[$];

  always #5 clk = ~clk;

  fetch_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_OUT(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_en          (pc_en),
    .pc_load        (pc_load),
    .pc_data        (pc_data),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // Memory contents as a pure function of the address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  // One clock: sample on the falling edge, update scoreboard and models,
  // then drive counter and memory responses just after the rising edge.
  task automatic tick();
    logic          fire;
    logic [AW-1:0] fire_addr, pc_next, a;
    logic [AW+DW-1:0] exp;
    @(negedge clk);
    fire      = mem_req & mem_gnt;
    fire_addr = mem_addr;
    pc_next   = pc_in;
    if (pc_load)    pc_next = pc_data;
    else if (pc_en) pc_next = pc_in + 8'd1;
    if (!rst) begin
      checks++;
      if (pc_en !== fire) begin
        errors++;
        $display("[TB] FAIL pc_en_vs_grant: got %b expected %b (cycle %0d)", pc_en, fire, cyc);
      end
    end
    if (rst || redirect_valid) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_unexpected: got pc=%0h instr=%0h expected nothing (cycle %0d)", out_pc, out_instr, cyc);
        end else begin
          exp = exp_q.pop_front();
          if ({out_pc, out_instr} !== exp) begin
            errors++;
            $display("[TB] FAIL sb_data: got pc=%0h instr=%0h expected pc=%0h instr=%0h (cycle %0d)",
                     out_pc, out_instr, exp[AW+DW-1:DW], exp[DW-1:0], cyc);
          end
        end
      end
      if (fire) exp_q.push_back({fire_addr, mem_word(fire_addr)});
    end
    if (fire) begin
      pend_addr.push_back(fire_addr);
      pend_due.push_back(cyc + mem_lat);
    end
    @(posedge clk);
    cyc++;
    #1;
    pc_in      = pc_next;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      a = pend_addr.pop_front();
      void'(pend_due.pop_front());
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(a);
    end
  endtask

  // Stop granting and let every read and buffered entry retire.
  task automatic quiesce();
    mem_gnt   = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    #1;
    checks++;
    if ({mem_req, pc_en, pc_load, out_valid} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {mem_req, pc_en, pc_load, out_valid});
    end
    checks++;
    if ({pc_data, out_pc, out_instr} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %0h/%0h/%0h expected 0/0/0", pc_data, out_pc, out_instr);
    end
  endtask

  task automatic test_stream();
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_req, pc_en, mem_addr} !== {2'b11, 8'h00}) begin
      errors++;
      $display("[TB] FAIL stream_first_issue: got req=%b en=%b addr=%0h expected 1 1 0", mem_req, pc_en, mem_addr);
    end
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_early_valid: got %b expected 0", out_valid);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 8'(i)) begin
        errors++;
        $display("[TB] FAIL stream_seq: got valid=%b pc=%0h expected valid=1 pc=%0h", out_valid, out_pc, i);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    repeat (10) tick();
    #1;
    checks++;
    if ({out_valid, mem_req, pc_en} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL bp_hold: got valid/req/en=%b expected 100", {out_valid, mem_req, pc_en});
    end
    checks++;
    if (exp_q.size() != DEPTH) begin
      errors++;
      $display("[TB] FAIL bp_held_count: got %0d expected %0d", exp_q.size(), DEPTH);
    end
    out_ready = 1'b1;
    mem_gnt   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_drain_valid: got %b expected 1 (entry %0d)", out_valid, i);
      end
      tick();
    end
    #1;
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL bp_drained: got valid=%b pending=%0d expected 0 0", out_valid, exp_q.size());
    end
    mem_gnt = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_redirect();
    int n;
    mem_lat = 3;
    quiesce();
    mem_gnt = 1'b1;
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    #1;
    checks++;
    if ({pc_load, pc_en, mem_req, pc_data} !== {3'b100, 8'h40}) begin
      errors++;
      $display("[TB] FAIL redirect_ctrl: got load/en/req=%b data=%0h expected 100 40", {pc_load, pc_en, mem_req}, pc_data);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, mem_req} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL redirect_drain1: got valid/req=%b expected 00", {out_valid, mem_req});
    end
    tick();
    #1;
    checks++;
    if ({out_valid, mem_req} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL redirect_drain2: got valid/req=%b expected 00", {out_valid, mem_req});
    end
    tick();
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h40) begin
      errors++;
      $display("[TB] FAIL redirect_resume: got req=%b addr=%0h expected 1 40", mem_req, mem_addr);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'h40) begin
      errors++;
      $display("[TB] FAIL redirect_first_pc: got valid=%b pc=%0h expected 1 40", out_valid, out_pc);
    end
    repeat (4) tick();
  endtask

  task automatic test_gnt_stall();
    logic [AW-1:0] addr0;
    mem_lat = 1;
    mem_gnt = 1'b0;
    tick();
    #1;
    addr0 = pc_in;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_addr !== addr0 || pc_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL gnt_stall: got addr=%0h en=%b expected %0h 0 (cycle %0d)", mem_addr, pc_en, addr0, i);
      end
      tick();
      #1;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL gnt_stall_req: got %b expected 1", mem_req);
    end
    mem_gnt = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    int n;
    logic [AW-1:0] exp_pc;
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    #1;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      #1;
      n++;
    end
    exp_pc = 8'hFE;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
        errors++;
        $display("[TB] FAIL wrap_seq: got valid=%b pc=%0h expected 1 %0h", out_valid, out_pc, exp_pc);
      end
      exp_pc = exp_pc + 8'd1;
      tick();
      #1;
    end
  endtask

  task automatic test_reset_midstream();
    mem_lat = 3;
    quiesce();
    mem_gnt = 1'b1;
    repeat (2) tick();
    rst     = 1'b1;
    mem_gnt = 1'b0;
    tick();
    #1;
    checks++;
    if ({mem_req, pc_en, pc_load, out_valid} !== 4'b0000 || {pc_data, out_pc, out_instr} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got req/en/load/valid=%b data=%0h pc=%0h instr=%0h expected all 0",
               {mem_req, pc_en, pc_load, out_valid}, pc_data, out_pc, out_instr);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_stray: got valid=%b expected 0 (cycle %0d)", out_valid, i);
      end
    end
    mem_gnt = 1'b1;
    mem_lat = 1;
    repeat (8) tick();
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_resume: got valid=%b expected 1", out_valid);
    end
  endtask

  initial begin
    rst            = 1'b1;
    pc_in          = '0;
    mem_gnt        = 1'b1;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    mem_lat        = 1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_gnt_stall();
    test_wrap();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
